// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM-style read port among NUM_REQ requesters.
// Exactly one read is outstanding at a time; the data return is steered back to the granted requester.
module mem_read_arbiter #(
  parameter  int NUM_REQ = 9,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 64,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [DATA_W-1:0]         req_readdata,
  output logic                      mem_read,
  output logic [ADDR_W-1:0]         mem_address,
  input  logic                      mem_waitrequest,
  input  logic [DATA_W-1:0]         mem_readdata,
  input  logic                      mem_readdatavalid,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   last;
  logic               found;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  pick_addr;

  // Rotating priority: first pass covers indices above last, second pass wraps to 0..last.
  always_comb begin
    found     = 1'b0;
    pick_idx  = '0;
    pick_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_read[i] && (i > 32'(last))) begin
        found     = 1'b1;
        pick_idx  = IDX_W'(i);
        pick_addr = req_address[i*ADDR_W +: ADDR_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_read[i]) begin
        found     = 1'b1;
        pick_idx  = IDX_W'(i);
        pick_addr = req_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_next        = state;
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    case (state)
      IDLE: begin
        if (found) state_next = ISSUE;
      end
      ISSUE: begin
        if (!mem_waitrequest) begin
          req_waitrequest[grant_idx] = 1'b0;
          state_next                 = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (mem_readdatavalid) begin
          req_readdatavalid[grant_idx] = 1'b1;
          state_next                   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_readdata = mem_readdata;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_address <= '0;
      grant_idx   <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
    end else begin
      state    <= state_next;
      mem_read <= (state_next == ISSUE);
      if (state == IDLE && found) begin
        grant_idx   <= pick_idx;
        mem_address <= pick_addr;
      end
      if (state == WAIT_DATA && mem_readdatavalid) last <= grant_idx;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed-vector bench for mem_read_arbiter with hand-computed expectations.
module tb_mem_read_arbiter;

  localparam int NUM_REQ = 9;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic [DATA_W-1:0]         req_readdata;
  logic                      mem_read;
  logic [ADDR_W-1:0]         mem_address;
  logic                      mem_waitrequest;
  logic [DATA_W-1:0]         mem_readdata;
  logic                      mem_readdatavalid;
  logic [IDX_W-1:0]          grant_idx;
  logic                      busy;

  int n_vec = 0;
  int n_err = 0;

  mem_read_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_read         (req_read),
    .req_address      (req_address),
    .req_waitrequest  (req_waitrequest),
    .req_readdatavalid(req_readdatavalid),
    .req_readdata     (req_readdata),
    .mem_read         (mem_read),
    .mem_address      (mem_address),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .grant_idx        (grant_idx),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int unsigned g);
    return 32'h1000 + 32'(g * 16);
  endfunction

  task automatic set_addrs;
    for (int unsigned i = 0; i < NUM_REQ; i++) req_address[i*ADDR_W +: ADDR_W] = addr_of(i);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  // Assumes IDLE with requests present and mem_waitrequest low; runs one full transaction.
  task automatic txn(input int unsigned g, input logic [63:0] d);
    tick;
    check_val("rr_grant", 64'(grant_idx), 64'(g));
    check_val("rr_mem_read", 64'(mem_read), 64'd1);
    check_val("rr_mem_addr", 64'(mem_address), 64'(addr_of(g)));
    tick;
    check_val("rr_mem_read_drop", 64'(mem_read), 64'd0);
    mem_readdata      = d;
    mem_readdatavalid = 1'b1;
    #1;
    check_val("rr_valid", 64'(req_readdatavalid), 64'(1) << g);
    check_val("rr_data", req_readdata, d);
    tick;
    mem_readdatavalid = 1'b0;
    check_val("rr_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int pulses;
    rst               = 1'b1;
    req_read          = '0;
    req_address       = '0;
    mem_waitrequest   = 1'b0;
    mem_readdata      = '0;
    mem_readdatavalid = 1'b0;

    // Reset held with random inputs
    for (int unsigned c = 0; c < 4; c++) begin
      req_read          = NUM_REQ'($urandom);
      req_address       = {9{$urandom}};
      mem_waitrequest   = 1'($urandom);
      mem_readdatavalid = 1'($urandom);
      mem_readdata      = {$urandom, $urandom};
      tick;
      check_val("rst_mem_read", 64'(mem_read), 64'd0);
      check_val("rst_mem_addr", 64'(mem_address), 64'd0);
      check_val("rst_grant", 64'(grant_idx), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_valid", 64'(req_readdatavalid), 64'd0);
      check_val("rst_waitreq", 64'(req_waitrequest), 64'h1FF);
    end
    req_read          = '0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    set_addrs;
    tick;
    rst = 1'b0;
    tick;

    // Single request from port 3
    req_address[3*ADDR_W +: ADDR_W] = 32'h40;
    req_read = 9'h008;
    #1;
    check_val("single_cyc0_mem_read", 64'(mem_read), 64'd0);
    tick;
    check_val("single_mem_read", 64'(mem_read), 64'd1);
    check_val("single_mem_addr", 64'(mem_address), 64'h40);
    check_val("single_grant", 64'(grant_idx), 64'd3);
    check_val("single_waitreq", 64'(req_waitrequest), 64'h1F7);
    req_read = '0;
    tick;
    check_val("single_mem_read_drop", 64'(mem_read), 64'd0);
    check_val("single_waitreq_wait", 64'(req_waitrequest), 64'h1FF);
    tick;
    mem_readdata      = 64'hDEAD_BEEF_0123_4567;
    mem_readdatavalid = 1'b1;
    #1;
    check_val("single_valid", 64'(req_readdatavalid), 64'h008);
    check_val("single_data", req_readdata, 64'hDEAD_BEEF_0123_4567);
    check_val("single_grant_hold", 64'(grant_idx), 64'd3);
    tick;
    mem_readdatavalid = 1'b0;
    check_val("single_idle", 64'(busy), 64'd0);

    // Round robin with all ports requesting, from reset
    set_addrs;
    do_reset;
    req_read = '1;
    for (int unsigned k = 0; k < 10; k++) txn(k % 9, 64'hA5A5_0000_0000_0000 + 64'(k));
    req_read = '0;

    // Rotation with sparse requests {1,4,7} from reset
    do_reset;
    req_read = 9'b0_1001_0010;
    txn(1, 64'h11);
    txn(4, 64'h44);
    txn(7, 64'h77);
    txn(1, 64'h1111);
    req_read = '0;

    // Stall in ISSUE for 5 cycles on port 2
    req_read        = 9'h004;
    mem_waitrequest = 1'b1;
    tick;
    for (int unsigned c = 0; c < 5; c++) begin
      check_val("stall_mem_read", 64'(mem_read), 64'd1);
      check_val("stall_mem_addr", 64'(mem_address), 64'(addr_of(2)));
      check_val("stall_waitreq", 64'(req_waitrequest), 64'h1FF);
      tick;
    end
    mem_waitrequest = 1'b0;
    #1;
    check_val("stall_release_waitreq", 64'(req_waitrequest), 64'h1FB);
    req_read = '0;
    tick;
    mem_readdata      = 64'h2222;
    mem_readdatavalid = 1'b1;
    #1;
    check_val("stall_valid", 64'(req_readdatavalid), 64'h004);
    tick;
    mem_readdatavalid = 1'b0;

    // Reset in WAIT_DATA, then a late valid
    req_read = 9'h040;
    tick;
    req_read = '0;
    tick;
    check_val("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_mem_read", 64'(mem_read), 64'd0);
    check_val("midrst_grant", 64'(grant_idx), 64'd0);
    mem_readdatavalid = 1'b1;
    #1;
    check_val("midrst_valid_in_rst", 64'(req_readdatavalid), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    check_val("midrst_late_valid", 64'(req_readdatavalid), 64'd0);
    check_val("midrst_idle", 64'(busy), 64'd0);
    mem_readdatavalid = 1'b0;

    // Stray valids in IDLE and ISSUE; port 5 drops its request before acceptance
    mem_readdatavalid = 1'b1;
    #1;
    check_val("stray_idle_valid", 64'(req_readdatavalid), 64'd0);
    tick;
    mem_readdatavalid = 1'b0;
    req_read        = 9'h020;
    mem_waitrequest = 1'b1;
    tick;
    check_val("drop_grant", 64'(grant_idx), 64'd5);
    req_read          = '0;
    mem_readdatavalid = 1'b1;
    #1;
    check_val("stray_issue_valid", 64'(req_readdatavalid), 64'd0);
    tick;
    mem_readdatavalid = 1'b0;
    check_val("drop_still_issue", 64'(mem_read), 64'd1);
    mem_waitrequest = 1'b0;
    tick;
    pulses = 0;
    for (int unsigned c = 0; c < 6; c++) begin
      mem_readdatavalid = (c == 1);
      mem_readdata      = 64'h5555_0000 + 64'(c);
      #1;
      if (req_readdatavalid[5]) pulses++;
      if (c == 1) begin
        check_val("drop_valid", 64'(req_readdatavalid), 64'h020);
        check_val("drop_data", req_readdata, 64'h5555_0001);
      end
      tick;
    end
    mem_readdatavalid = 1'b0;
    check_val("drop_pulse_count", 64'(pulses), 64'd1);
    check_val("drop_final_idle", 64'(busy), 64'd0);
    check_val("drop_no_reissue", 64'(mem_read), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
